// File: rtl/mux_3to1.sv
//------------------------------------------------------------------------------
// Module   : mux_3to1
// Purpose  : N-bit 3-to-1 selector with a combinational output and a
//            registered copy (1-cycle latency, synchronous reset to zero).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_3to1 #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] IN0,
   input  logic [N-1:0] IN1,
   input  logic [N-1:0] IN2,
   input  logic         S0,
   input  logic         S1,
   output logic [N-1:0] OUT,
   output logic [N-1:0] OUT_R
);

   logic [N-1:0] w_out;
   logic [N-1:0] r_out;

   // Ternary form lets X/Z on the selects reach the outputs instead of
   // silently defaulting to one input; S1 dominates so sel=11 picks IN2.
   always_comb begin
      w_out = S1 ? IN2 : (S0 ? IN1 : IN0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_out;
      end
   end

   assign OUT   = w_out;
   assign OUT_R = r_out;

endmodule

`default_nettype wire

// File: tb/tb_mux_3to1.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_3to1
// Purpose  : Self-checking bench for mux_3to1: directed select/reset cases
//            followed by randomized traffic against a table-lookup model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_3to1;

   localparam int c_N = 16;

   logic           clk;
   logic           rst;
   logic [c_N-1:0] in0, in1, in2;
   logic           s0, s1;
   logic [c_N-1:0] out, out_r;

   int checks = 0;
   int errors = 0;

   mux_3to1 #(.N(c_N)) dut (
      .clk   (clk),
      .rst   (rst),
      .IN0   (in0),
      .IN1   (in1),
      .IN2   (in2),
      .S0    (s0),
      .S1    (s1),
      .OUT   (out),
      .OUT_R (out_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [c_N-1:0] obs,
                           input logic [c_N-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: the selected word is a lookup into a 3-entry table,
   // with the unused code 3 folded onto entry 2.
   function automatic logic [c_N-1:0] ref_mux(input logic a1, input logic a0,
                                              input logic [c_N-1:0] d0,
                                              input logic [c_N-1:0] d1,
                                              input logic [c_N-1:0] d2);
      logic [c_N-1:0] table_w [3];
      int idx;
      table_w[0] = d0;
      table_w[1] = d1;
      table_w[2] = d2;
      idx = 2 * int'(a1) + int'(a0);
      if (idx > 2) idx = 2;
      return table_w[idx];
   endfunction

   task automatic apply(input string tag, input logic a1, input logic a0,
                        input logic [c_N-1:0] d0, input logic [c_N-1:0] d1,
                        input logic [c_N-1:0] d2);
      s1  = a1;
      s0  = a0;
      in0 = d0;
      in1 = d1;
      in2 = d2;
      #1;
      check_eq(tag, out, ref_mux(a1, a0, d0, d1, d2));
   endtask

   task automatic step(input string tag);
      logic [c_N-1:0] exp;
      exp = rst ? '0 : ref_mux(s1, s0, in0, in1, in2);
      @(posedge clk);
      #1;
      check_eq(tag, out_r, exp);
   endtask

   initial begin
      rst = 1'b1;
      s0  = 1'b0;
      s1  = 1'b0;
      in0 = 16'h0F0F;
      in1 = 16'hF0F0;
      in2 = 16'hFFFF;

      step("reset_state");
      check_eq("reset_state_const", out_r, 16'h0000);
      rst = 1'b0;

      apply("sel00_out", 1'b0, 1'b0, 16'h0F0F, 16'hF0F0, 16'hFFFF);
      check_eq("sel00_out_const", out, 16'h0F0F);
      step("sel00_outr");
      check_eq("sel00_outr_const", out_r, 16'h0F0F);

      apply("sel01_out", 1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 16'hFFFF);
      check_eq("sel01_out_const", out, 16'hF0F0);
      step("sel01_outr");

      apply("sel10_out", 1'b1, 1'b0, 16'h0F0F, 16'hF0F0, 16'hFFFF);
      step("sel10_outr");

      apply("sel11_out", 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 16'hFFFF);
      check_eq("sel11_out_const", out, 16'hFFFF);
      step("sel11_outr");

      // Reset mid-stream with sel=01
      apply("rst_sel01_out", 1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 16'hFFFF);
      rst = 1'b1;
      step("rst_outr_zero");
      check_eq("rst_out_muxing", out, 16'hF0F0);
      rst = 1'b0;
      step("rst_release_outr");
      check_eq("rst_release_const", out_r, 16'hF0F0);

      // Data change between edges: OUT immediate, OUT_R waits for the edge
      apply("in1_change_out", 1'b0, 1'b1, 16'h0F0F, 16'h1234, 16'hFFFF);
      check_eq("in1_change_outr_hold", out_r, 16'hF0F0);
      step("in1_change_outr");
      check_eq("in1_change_outr_const", out_r, 16'h1234);

      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(0, 9) == 0);
         apply("rand_out", 1'($urandom), 1'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom));
         step("rand_outr");
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
